// File: rtl/fifo_byte_packer.sv
// Drains a 1-cycle-latency byte FIFO and packs bytes little-endian into OUT_W-bit stream words.
// Optional idle auto-flush is enabled by defining FIFO_PACK_TIMEOUT_EN.
module fifo_byte_packer #(
    parameter int unsigned OUT_W   = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fifo_empty,
    output logic               fifo_rd_en,
    input  logic [7:0]         fifo_rd_data,
    input  logic               flush,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [OUT_W-1:0]   m_data,
    output logic [OUT_W/8-1:0] m_keep,
    output logic               m_last
);

    localparam int unsigned BYTES = OUT_W / 8;
    localparam int unsigned CntW  = $clog2(BYTES + 1);

    typedef enum logic [1:0] {StAccum, StDrain, StEmit} state_e;

    state_e             state_q, state_d;
    logic [OUT_W-1:0]   asm_q, asm_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic               flush_req_q, flush_req_d;
    logic               last_q, last_d;
    logic               m_valid_q, m_valid_d;
    logic [OUT_W-1:0]   m_data_q, m_data_d;
    logic [BYTES-1:0]   m_keep_q, m_keep_d;
    logic               m_last_q, m_last_d;

    logic               flush_in;
    logic               room;
    logic               rd_acc;
    logic               full_cap;

`ifdef FIFO_PACK_TIMEOUT_EN
    localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

    logic [IdleW-1:0] idle_q, idle_d;
    logic             timeout_hit;

    always_comb begin
        idle_d      = idle_q;
        timeout_hit = 1'b0;
        if (state_q != StAccum || pend_q) begin
            idle_d = '0;
        end else if (cnt_q != '0 && fifo_empty) begin
            // The cycle that would bring the count to TIMEOUT acts as a flush.
            if (idle_q == IdleW'(TIMEOUT - 1)) begin
                timeout_hit = 1'b1;
                idle_d      = '0;
            end else begin
                idle_d = idle_q + IdleW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end

    assign flush_in = flush | timeout_hit;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign flush_in       = flush;
`endif

    assign room       = ({1'b0, cnt_q} + {{CntW{1'b0}}, pend_q}) < (CntW + 1)'(BYTES);
    assign fifo_rd_en = rst && (state_q == StAccum) && !fifo_empty && room && !flush_req_q;
    assign rd_acc     = fifo_rd_en && !fifo_empty;
    assign full_cap   = pend_q && (cnt_q == CntW'(BYTES - 1));

    always_comb begin
        state_d     = state_q;
        asm_d       = asm_q;
        cnt_d       = cnt_q;
        pend_d      = rd_acc;
        flush_req_d = flush_req_q | flush_in;
        last_d      = last_q;
        m_valid_d   = m_valid_q && !m_ready;
        m_data_d    = m_data_q;
        m_keep_d    = m_keep_q;
        m_last_d    = m_last_q;

        // Capture of the byte read last cycle happens regardless of state.
        if (pend_q) begin
            for (int i = 0; i < BYTES; i++) begin
                if (cnt_q == CntW'(i)) begin
                    asm_d[8*i +: 8] = fifo_rd_data;
                end
            end
            cnt_d = cnt_q + CntW'(1);
        end

        unique case (state_q)
            StAccum: begin
                if (full_cap) begin
                    state_d = StEmit;
                    if (flush_in) begin
                        last_d = 1'b1;
                    end
                end else if (flush_req_d) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!pend_q) begin
                    if (cnt_q == '0) begin
                        state_d     = StAccum;
                        flush_req_d = 1'b0;
                    end else begin
                        state_d = StEmit;
                        last_d  = 1'b1;
                    end
                end
            end
            StEmit: begin
                if (flush_in) begin
                    last_d = 1'b1;
                end
                if (!m_valid_q || m_ready) begin
                    m_valid_d = 1'b1;
                    m_data_d  = asm_q;
                    m_last_d  = last_q | flush_in;
                    for (int i = 0; i < BYTES; i++) begin
                        m_keep_d[i] = CntW'(i) < cnt_q;
                    end
                    asm_d       = '0;
                    cnt_d       = '0;
                    last_d      = 1'b0;
                    flush_req_d = 1'b0;
                    state_d     = StAccum;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StAccum;
            asm_q       <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            flush_req_q <= 1'b0;
            last_q      <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_keep_q    <= '0;
            m_last_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            asm_q       <= asm_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            flush_req_q <= flush_req_d;
            last_q      <= last_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_keep_q    <= m_keep_d;
            m_last_q    <= m_last_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_keep  = m_keep_q;
    assign m_last  = m_last_q;

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Directed bench for fifo_byte_packer (OUT_W=32) with a 1-cycle-latency byte FIFO model.
module tb_fifo_byte_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  fifo_rd_data = 8'h00;
    logic        flush = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last;

    int asserts = 0;
    int fails   = 0;

    fifo_byte_packer #(
        .OUT_W   (32),
        .TIMEOUT (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .flush        (flush),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_keep       (m_keep),
        .m_last       (m_last)
    );

    always #5 clk = ~clk;

    // Byte FIFO model with one cycle of read latency.
    logic [7:0] mem [0:255];
    int   wr_ptr   = 0;
    int   rd_ptr   = 0;
    int   cyc      = 0;
    int   data_cyc = 0;
    logic stall    = 1'b0;
    logic ovr      = 1'b0;

    assign fifo_empty = ovr ? 1'b0 : (stall || (rd_ptr == wr_ptr));

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en && !fifo_empty) begin
            fifo_rd_data <= mem[rd_ptr];
            rd_ptr       <= rd_ptr + 1;
            data_cyc     <= cyc + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output monitor, sampled mid-cycle.
    logic [31:0] wd [0:63];
    logic [3:0]  wk [0:63];
    logic        wl [0:63];
    int          nwords       = 0;
    int          rise_cyc     = 0;
    int          flush_cyc    = 0;
    int          valid_cycles = 0;
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic [36:0] pword = '0;

    always @(negedge clk) begin
        if (rst) begin
            if (pv && !pr) begin
                check("hold_valid", 64'(m_valid), 64'(1));
                check("hold_word", 64'({m_data, m_keep, m_last}), 64'(pword));
            end
            if (m_valid && !pv) rise_cyc = cyc;
            if (m_valid) valid_cycles++;
            if (m_valid && m_ready) begin
                wd[nwords] = m_data;
                wk[nwords] = m_keep;
                wl[nwords] = m_last;
                nwords++;
            end
            if (flush) flush_cyc = cyc;
        end
        pv    = m_valid;
        pr    = m_ready;
        pword = {m_data, m_keep, m_last};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr++;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic drain_fifo();
        int k = 0;
        while (rd_ptr != wr_ptr && k < 50) begin
            tick();
            k++;
        end
        check("fifo_drained", 64'(rd_ptr), 64'(wr_ptr));
        tick();
        tick();
    endtask

    task automatic wait_words(input int n, input int budget, input string name);
        int k = 0;
        while (nwords < n && k < budget) begin
            tick();
            k++;
        end
        check(name, 64'(nwords), 64'(n));
    endtask

    task automatic check_word(input int idx, input logic [31:0] d, input logic [3:0] kp,
                              input logic l, input string name);
        check({name, "_data"}, 64'(wd[idx]), 64'(d));
        check({name, "_keep"}, 64'(wk[idx]), 64'(kp));
        check({name, "_last"}, 64'(wl[idx]), 64'(l));
    endtask

    typedef struct {
        int          nbytes;
        logic [7:0]  b [4];
        logic        do_flush;
        logic [31:0] exp_data;
        logic [3:0]  exp_keep;
        logic        exp_last;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int base_w;
        int base_r;
        logic [31:0] exp_w;

        vecs[0] = '{4, '{8'h01, 8'h02, 8'h03, 8'h04}, 1'b0, 32'h04030201, 4'hF, 1'b0};
        vecs[1] = '{4, '{8'hDE, 8'hAD, 8'hBE, 8'hEF}, 1'b0, 32'hEFBEADDE, 4'hF, 1'b0};
        vecs[2] = '{3, '{8'h10, 8'h20, 8'h30, 8'h00}, 1'b1, 32'h00302010, 4'h7, 1'b1};
        vecs[3] = '{1, '{8'h5A, 8'h00, 8'h00, 8'h00}, 1'b1, 32'h0000005A, 4'h1, 1'b1};
        vecs[4] = '{2, '{8'hFF, 8'h00, 8'h00, 8'h00}, 1'b1, 32'h000000FF, 4'h3, 1'b1};
        vecs[5] = '{4, '{8'h00, 8'h00, 8'h00, 8'h80}, 1'b0, 32'h80000000, 4'hF, 1'b0};

        // Reset with a non-empty FIFO and flush asserted.
        rst   = 1'b0;
        ovr   = 1'b1;
        flush = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_rd_en", 64'(fifo_rd_en), 64'(0));
            check("rst_valid", 64'(m_valid), 64'(0));
            check("rst_data", 64'(m_data), 64'(0));
            check("rst_keep", 64'(m_keep), 64'(0));
            check("rst_last", 64'(m_last), 64'(0));
        end
        @(posedge clk);
        #1;
        rst     = 1'b1;
        ovr     = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b1;
        tick();

        // Single word and its latency.
        base_r       = rd_ptr;
        valid_cycles = 0;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_words(1, 40, "single_count");
        repeat (4) tick();
        check_word(0, 32'h44332211, 4'hF, 1'b0, "single");
        check("single_latency", 64'(rise_cyc - data_cyc), 64'(2));
        check("single_reads", 64'(rd_ptr - base_r), 64'(4));
        check("single_valid_cycles", 64'(valid_cycles), 64'(1));

        // Table vectors.
        for (int v = 0; v < 6; v++) begin
            base_w = nwords;
            for (int j = 0; j < vecs[v].nbytes; j++) push(vecs[v].b[j]);
            drain_fifo();
            if (vecs[v].do_flush) pulse_flush();
            wait_words(base_w + 1, 40, "vec_count");
            check_word(base_w, vecs[v].exp_data, vecs[v].exp_keep, vecs[v].exp_last, "vec");
            repeat (2) tick();
        end

        // Backpressure: one word held at the output, one held in EMIT.
        m_ready = 1'b0;
        base_w  = nwords;
        base_r  = rd_ptr;
        for (int i = 0; i < 12; i++) push(8'h40 + 8'(i));
        repeat (30) tick();
        check("bp_reads_stalled", 64'(rd_ptr - base_r), 64'(8));
        check("bp_valid", 64'(m_valid), 64'(1));
        check("bp_held_data", 64'(m_data), 64'(32'h43424140));
        check("bp_no_accept", 64'(nwords), 64'(base_w));
        m_ready = 1'b1;
        wait_words(base_w + 3, 60, "bp_count");
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 4; j++) exp_w[8*j +: 8] = 8'h40 + 8'(4 * k + j);
            check_word(base_w + k, exp_w, 4'hF, 1'b0, "bp_word");
        end
        check("bp_reads_total", 64'(rd_ptr - base_r), 64'(12));
        repeat (3) tick();

        // Flush of a partial word and its latency.
        base_w = nwords;
        push(8'hAA); push(8'hBB);
        drain_fifo();
        stall = 1'b1;
        pulse_flush();
        wait_words(base_w + 1, 20, "fl_count");
        check_word(base_w, 32'h0000BBAA, 4'h3, 1'b1, "flush_partial");
        check("flush_latency", 64'(rise_cyc - flush_cyc), 64'(3));
        repeat (3) tick();

        // Flush with nothing assembled produces no word.
        base_w = nwords;
        pulse_flush();
        repeat (10) tick();
        check("empty_flush_words", 64'(nwords), 64'(base_w));
        check("empty_flush_valid", 64'(m_valid), 64'(0));
        stall = 1'b0;
        push(8'h01); push(8'h23); push(8'h45); push(8'h67);
        wait_words(base_w + 1, 40, "post_flush_count");
        check_word(base_w, 32'h67452301, 4'hF, 1'b0, "post_flush");
        repeat (3) tick();

        // Idle partial word: auto-flush only when the timeout is built in.
        base_w = nwords;
        push(8'h01); push(8'h02); push(8'h03);
        drain_fifo();
        stall = 1'b1;
`ifdef FIFO_PACK_TIMEOUT_EN
        wait_words(base_w + 1, 40, "timeout_count");
        check_word(base_w, 32'h00030201, 4'h7, 1'b1, "timeout");
`else
        repeat (100) tick();
        check("no_timeout_words", 64'(nwords), 64'(base_w));
        pulse_flush();
        wait_words(base_w + 1, 20, "late_flush_count");
        check_word(base_w, 32'h00030201, 4'h7, 1'b1, "late_flush");
`endif
        stall = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
